// File: rtl/hpdmc_iodelay_ctl_pkg.sv
// Shared definitions for the IODELAY2 sequencer: state encodings, counter widths
// and the tap-width default also used by the hpdmc CSR block.
package hpdmc_iodelay_ctl_pkg;

    localparam int TAP_WIDTH_DEFAULT = 8;
    localparam int GUARD_CNT_W       = 16;
    localparam int RECAL_CNT_W       = 32;

    typedef enum logic [3:0] {
        S_CAL        = 4'd0,
        S_CAL_GUARD  = 4'd1,
        S_CAL_WAIT   = 4'd2,
        S_RST        = 4'd3,
        S_RST_GUARD  = 4'd4,
        S_RST_WAIT   = 4'd5,
        S_DECIDE     = 4'd6,
        S_STEP       = 4'd7,
        S_STEP_GUARD = 4'd8,
        S_STEP_WAIT  = 4'd9,
        S_IDLE       = 4'd10
    } state_t;

    function automatic logic is_pulse(input state_t s);
        return (s == S_CAL) || (s == S_RST) || (s == S_STEP);
    endfunction

    function automatic logic is_timed(input state_t s);
        return (s == S_CAL_GUARD) || (s == S_CAL_WAIT) || (s == S_RST_GUARD) ||
               (s == S_RST_WAIT) || (s == S_STEP_GUARD) || (s == S_STEP_WAIT);
    endfunction

endpackage

// File: rtl/hpdmc_iodelay_ctl_timer.sv
// Loadable down-counter that holds at zero; reset loads the reload value so a
// periodic user starts a full period after reset.
module hpdmc_iodelay_ctl_timer #(
    parameter int WIDTH = 16
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [WIDTH-1:0] cnt;

    always_ff @(posedge sys_clk) begin
        if (sys_rst || load)
            cnt <= load_val;
        else if (en && (cnt != '0))
            cnt <= cnt - WIDTH'(1);
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/hpdmc_iodelay_ctl.sv
// IODELAY2 sequencer: power-up calibration, single-tap moves to a requested
// target, periodic recalibration, and a sticky timeout on a stuck BUSY.
//
// state      | meaning
// CAL        | one-cycle CAL pulse
// RST        | one-cycle RST pulse, tap tracking returns to 0
// STEP       | one-cycle CE pulse, INC toward target
// *_GUARD    | BUSY ignored for BUSY_GUARD cycles after a pulse
// *_WAIT     | wait for BUSY low, abort after TIMEOUT busy cycles
// DECIDE     | compare tap with target
// IDLE       | ready for requests
module hpdmc_iodelay_ctl
    import hpdmc_iodelay_ctl_pkg::*;
#(
    parameter int TAP_WIDTH    = TAP_WIDTH_DEFAULT,
    parameter int MAX_TAP      = 255,
    parameter int BUSY_GUARD   = 2,
    parameter int TIMEOUT      = 1023,
    parameter int RECAL_PERIOD = 0
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 set_req,
    input  logic [TAP_WIDTH-1:0] set_tap,
    input  logic                 cal_req,
    output logic                 ready,
    output logic [TAP_WIDTH-1:0] cur_tap,
    output logic                 err,
    input  logic                 iodelay_busy,
    output logic                 iodelay_cal,
    output logic                 iodelay_rst,
    output logic                 iodelay_ce,
    output logic                 iodelay_inc
);

    localparam logic [TAP_WIDTH-1:0]   MAX_TAP_T  = TAP_WIDTH'(MAX_TAP);
    localparam logic [GUARD_CNT_W-1:0] GUARD_LOAD = GUARD_CNT_W'(BUSY_GUARD - 1);
    localparam logic [GUARD_CNT_W-1:0] TMO_LOAD   = GUARD_CNT_W'(TIMEOUT - 1);
    localparam logic [RECAL_CNT_W-1:0] RECAL_LOAD = RECAL_CNT_W'(RECAL_PERIOD - 1);
    localparam logic                   RECAL_EN   = (RECAL_PERIOD != 0);

    state_t               state_q, state_d;
    logic [TAP_WIDTH-1:0] cur_tap_q, target_q;
    logic                 err_q, pending_q;
    logic                 cal_c, rst_c, ce_c, inc_c;
    logic                 tmr_load, tmr_zero, recal_zero, recal_expire;
    logic                 tap_clr, tap_step, err_set, latch, enter_cal;

    hpdmc_iodelay_ctl_timer #(.WIDTH(GUARD_CNT_W)) u_guard_tmr (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .load     (tmr_load),
        .load_val (is_pulse(state_q) ? GUARD_LOAD : TMO_LOAD),
        .en       (is_timed(state_q)),
        .zero     (tmr_zero)
    );

    hpdmc_iodelay_ctl_timer #(.WIDTH(RECAL_CNT_W)) u_recal_tmr (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .load     (recal_expire),
        .load_val (RECAL_LOAD),
        .en       (RECAL_EN),
        .zero     (recal_zero)
    );

    assign recal_expire = recal_zero && RECAL_EN;

    always_comb begin
        state_d   = state_q;
        cal_c     = 1'b0;
        rst_c     = 1'b0;
        ce_c      = 1'b0;
        inc_c     = 1'b0;
        tmr_load  = 1'b0;
        tap_clr   = 1'b0;
        tap_step  = 1'b0;
        err_set   = 1'b0;
        latch     = 1'b0;
        enter_cal = 1'b0;
        case (state_q)
            S_CAL: begin
                cal_c    = 1'b1;
                tmr_load = 1'b1;
                state_d  = S_CAL_GUARD;
            end
            S_CAL_GUARD: if (tmr_zero) begin
                tmr_load = 1'b1;
                state_d  = S_CAL_WAIT;
            end
            S_CAL_WAIT: begin
                if (!iodelay_busy) state_d = S_RST;
                else if (tmr_zero) begin
                    err_set = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_RST: begin
                rst_c    = 1'b1;
                tmr_load = 1'b1;
                tap_clr  = 1'b1;
                state_d  = S_RST_GUARD;
            end
            S_RST_GUARD: if (tmr_zero) begin
                tmr_load = 1'b1;
                state_d  = S_RST_WAIT;
            end
            S_RST_WAIT: begin
                if (!iodelay_busy) state_d = S_DECIDE;
                else if (tmr_zero) begin
                    err_set = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_DECIDE: state_d = (cur_tap_q == target_q) ? S_IDLE : S_STEP;
            S_STEP: begin
                ce_c     = 1'b1;
                inc_c    = (target_q > cur_tap_q);
                tmr_load = 1'b1;
                tap_step = 1'b1;
                state_d  = S_STEP_GUARD;
            end
            S_STEP_GUARD: if (tmr_zero) begin
                tmr_load = 1'b1;
                state_d  = S_STEP_WAIT;
            end
            S_STEP_WAIT: begin
                if (!iodelay_busy) state_d = S_DECIDE;
                else if (tmr_zero) begin
                    err_set = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (cal_req || pending_q) begin
                    enter_cal = 1'b1;
                    state_d   = S_CAL;
                end else if (set_req) begin
                    latch   = 1'b1;
                    state_d = S_DECIDE;
                end
            end
            default: state_d = S_CAL;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q   <= S_CAL;
            cur_tap_q <= '0;
            target_q  <= '0;
            err_q     <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (tap_clr)
                cur_tap_q <= '0;
            else if (tap_step)
                cur_tap_q <= inc_c ? cur_tap_q + TAP_WIDTH'(1) : cur_tap_q - TAP_WIDTH'(1);
            if (latch)
                target_q <= (set_tap > MAX_TAP_T) ? MAX_TAP_T : set_tap;
            if (err_set)
                err_q <= 1'b1;
            // an expiry on the same edge as CAL entry stays pending
            pending_q <= recal_expire || (pending_q && !enter_cal);
        end
    end

    // state sits at CAL throughout reset; keep the pins quiet until release
    assign iodelay_cal = cal_c && !sys_rst;
    assign iodelay_rst = rst_c && !sys_rst;
    assign iodelay_ce  = ce_c  && !sys_rst;
    assign iodelay_inc = inc_c && !sys_rst;
    assign ready       = (state_q == S_IDLE);
    assign cur_tap     = cur_tap_q;
    assign err         = err_q;

endmodule
